// File: rtl/vga_timing_gen.sv
// Raster timing source: DrawX/DrawY counters with blank, hs, vs and line/frame pulses.
// Latency: all outputs registered, updated on the same vga_clk edge that advances the counters.
// Backpressure: none; pix_en=0 holds the raster and suppresses pulses. VGA_FRAME_CNT_EN adds frame_count.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       vis_nxt;
    logic       hs_act_nxt;
    logic       vs_act_nxt;

    // Next raster position and its decodes, so registered outputs land together with the counters.
    always_comb begin
        h_wrap     = (DrawX == H_LAST);
        v_wrap     = h_wrap && (DrawY == V_LAST);
        x_nxt      = h_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt      = DrawY;
        if (h_wrap) begin
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        vis_nxt    = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_act_nxt = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
        vs_act_nxt = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    end

    // Raster state: reset parks on the last pixel so the first enabled pixel is (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= vis_nxt;
            hs          <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
            vs          <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter steps on the same edge that raises frame_start; wraps naturally at 16 bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 16'd0;
        end else if (pix_en && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a small, positive-sync instance.
// Expected values come from the pixel index since reset (advance count), decomposed into x/y.
// Stimulus: directed phases of continuous, alternating and random pix_en plus async resets.
module tb_vga_timing_gen;

    // Small instance geometry: 64 x 19 raster, positive sync polarity.
    localparam int S_HV = 40, S_HF = 6, S_HS = 10, S_HB = 8;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2,  S_VB = 3;
    localparam bit S_POL = 1'b1;

    logic       vga_clk;
    logic       reset_n;
    logic       pix_en;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_blank, d_hs, d_vs, d_ls, d_fs;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    int total = 0;
    int bad   = 0;
    int n     = 0;      // pixels advanced since the last reset
    bit adv   = 1'b0;   // whether the most recent edge advanced
    int fc_base = 0;    // offset applied to the small instance frame count after a preload

    vga_timing_gen u_d (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .blank       (d_blank),
        .hs          (d_hs),
        .vs          (d_vs),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (d_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL  (S_POL)
    ) u_s (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .blank       (s_blank),
        .hs          (s_hs),
        .vs          (s_vs),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (s_fc)
`endif
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic cmp(input string t, input string f, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0d expected=%0d (n=%0d)", t, f, obs, exp, n);
        end
    endtask

    // Frames started after cnt advances: the counter first reaches pixel 0 at advance 1.
    function automatic int frames(input int cnt, input int ft);
        return (cnt + ft - 1) / ft;
    endfunction

    // Reference: the raster is a flat pixel index; reset sits on the last index of a frame.
    task automatic check_inst(input string t,
                              input int hv, input int hf, input int hsw, input int hb,
                              input int vv, input int vf, input int vsw, input int vb,
                              input bit pol,
                              input logic [9:0] ox, input logic [9:0] oy,
                              input logic ob, input logic ohs, input logic ovs,
                              input logic ols, input logic ofs);
        int ht, vt, ft, pos, ex, ey;
        bit eb, ehs, evs, els, efs;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        ft  = ht * vt;
        pos = (n + ft - 1) % ft;
        ex  = pos % ht;
        ey  = pos / ht;
        eb  = (ex < hv) && (ey < vv);
        ehs = (ex >= hv + hf && ex < hv + hf + hsw) ? pol : ~pol;
        evs = (ey >= vv + vf && ey < vv + vf + vsw) ? pol : ~pol;
        els = adv && (ex == 0);
        efs = adv && (pos == 0);
        cmp(t, "DrawX", 32'(ox), 32'(ex));
        cmp(t, "DrawY", 32'(oy), 32'(ey));
        cmp(t, "blank", 32'(ob), 32'(eb));
        cmp(t, "hs", 32'(ohs), 32'(ehs));
        cmp(t, "vs", 32'(ovs), 32'(evs));
        cmp(t, "line_start", 32'(ols), 32'(els));
        cmp(t, "frame_start", 32'(ofs), 32'(efs));
    endtask

    task automatic check_all(input string t);
        check_inst({t, "/def"}, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                   d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs);
        check_inst({t, "/small"}, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_POL,
                   s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs);
`ifdef VGA_FRAME_CNT_EN
        cmp({t, "/def"}, "frame_count", 32'(d_fc), 32'(frames(n, 800 * 525) % 65536));
        cmp({t, "/small"}, "frame_count", 32'(s_fc),
            32'((frames(n, 64 * 19) + fc_base) % 65536));
`endif
    endtask

    // mode 0: pix_en always 1; mode 1: alternate 1/0; mode 2: random, mostly enabled.
    task automatic run(input string t, input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = (i % 2 == 0);
                default: pix_en = ($urandom_range(0, 3) != 0);
            endcase
            @(posedge vga_clk);
            adv = pix_en;
            if (pix_en) n++;
            #1;
            check_all(t);
        end
    endtask

    initial begin
        pix_en  = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n = 0; adv = 1'b0;
        check_all("reset_async");
        repeat (3) @(posedge vga_clk);
        #1;
        check_all("reset_hold");
        reset_n = 1'b1;

        // Continuous pixels: first edge gives (0,0) with both pulses; two small frames and change.
        run("cont", 3000, 0);
        run("alt", 2000, 1);

`ifdef VGA_FRAME_CNT_EN
        // Preload the small instance counter to its wrap point; next frame start reads 0.
        force u_s.frame_cnt_q = 16'hFFFF;
        #1 release u_s.frame_cnt_q;
        fc_base = 65535 - (frames(n, 64 * 19) % 65536);
        check_all("preload");
`endif

        run("rand", 5000, 2);

        // Mid-frame reset: outputs must return to reset values with no clock edge.
        reset_n = 1'b0;
        #1;
        n = 0; adv = 1'b0; fc_base = 0;
        check_all("midreset_async");
        @(posedge vga_clk);
        #1;
        check_all("midreset_hold");
        reset_n = 1'b1;

        run("after_reset", 1500, 0);
        run("rand2", 3000, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
